// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave front end for the 16-entry register bank: address decode,
// read-only enforcement, byte-strobe merge by read-modify-write, and responses.
module axil_reg_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 16,
  parameter logic [15:0] RO_MASK   = 16'h0008
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awprot,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic        write_en,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic [31:0] read_addr,
  input  logic [31:0] read_data
);

  localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

  w_state_t    w_state, w_next;
  logic        aw_done, aw_done_n, w_done, w_done_n;
  logic [31:0] awaddr_q, awaddr_n, wdata_q, wdata_n;
  logic [3:0]  wstrb_q, wstrb_n;
  logic        awready_q, awready_n, wready_q, wready_n;
  logic [1:0]  bresp_q, bresp_n;

  r_state_t    r_state, r_next;
  logic [31:0] araddr_q, araddr_n, rdata_q, rdata_n;
  logic        arready_q, arready_n;
  logic [1:0]  rresp_q, rresp_n;

  logic [31:0] w_off, r_off, strb_mask;
  logic        w_hit, r_hit;
  logic [3:0]  w_idx, r_idx;

  logic unused_prot;
  assign unused_prot = ^{s_awprot, s_arprot};

  assign w_off     = awaddr_q - BASE_ADDR;
  assign w_hit     = w_off < WIN_BYTES;
  assign w_idx     = w_off[5:2];
  assign r_off     = araddr_q - BASE_ADDR;
  assign r_hit     = r_off < WIN_BYTES;
  assign r_idx     = r_off[5:2];
  assign strb_mask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = (w_state == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = (r_state == R_RESP);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_state   <= W_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state   <= w_next;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      awaddr_q  <= awaddr_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bresp_q   <= bresp_n;
    end
  end

  always_comb begin
    w_next     = w_state;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    awaddr_n   = awaddr_q;
    wdata_n    = wdata_q;
    wstrb_n    = wstrb_q;
    awready_n  = awready_q;
    wready_n   = wready_q;
    bresp_n    = bresp_q;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    case (w_state)
      W_IDLE: begin
        if (s_awvalid && awready_q) begin
          aw_done_n = 1'b1;
          awaddr_n  = s_awaddr;
        end
        if (s_wvalid && wready_q) begin
          w_done_n = 1'b1;
          wdata_n  = s_wdata;
          wstrb_n  = s_wstrb;
        end
        awready_n = !aw_done_n;
        wready_n  = !w_done_n;
        if (aw_done_n && w_done_n) w_next = W_COMMIT;
      end
      W_COMMIT: begin
        w_next = W_RESP;
        if (!w_hit) begin
          bresp_n = RESP_DECERR;
        end else if (RO_MASK[w_idx]) begin
          bresp_n = RESP_SLVERR;
        end else begin
          bresp_n = RESP_OKAY;
          // read_data here is the current contents of the target register
          if (wstrb_q != 4'b0000) begin
            write_en   = 1'b1;
            write_addr = {26'b0, w_idx, 2'b00};
            write_data = (read_data & ~strb_mask) | (wdata_q & strb_mask);
          end
        end
      end
      W_RESP: begin
        if (s_bready) begin
          w_next    = W_IDLE;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= R_IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      arready_q <= 1'b0;
    end else begin
      r_state   <= r_next;
      araddr_q  <= araddr_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
      arready_q <= arready_n;
    end
  end

  always_comb begin
    r_next    = r_state;
    araddr_n  = araddr_q;
    rdata_n   = rdata_q;
    rresp_n   = rresp_q;
    arready_n = arready_q;
    case (r_state)
      R_IDLE: begin
        if (s_arvalid && arready_q) begin
          araddr_n  = s_araddr;
          arready_n = 1'b0;
          r_next    = R_FETCH;
        end else begin
          arready_n = 1'b1;
        end
      end
      R_FETCH: begin
        // a committing write owns the read port this cycle
        if (w_state != W_COMMIT) begin
          r_next  = R_RESP;
          rdata_n = r_hit ? read_data : 32'h0;
          rresp_n = r_hit ? RESP_OKAY : RESP_DECERR;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          r_next    = R_IDLE;
          arready_n = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    read_addr = '0;
    if (w_state == W_COMMIT)     read_addr = {26'b0, w_idx, 2'b00};
    else if (r_state == R_FETCH) read_addr = {26'b0, r_idx, 2'b00};
  end

endmodule
